// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver: 8N1 serial-to-parallel receiver with 16x oversampling.
// The RxD line passes through a two-flop synchroniser. Each bit is sampled at
// its centre and shifted LSB-first into RSDR. A completed frame moves into the
// receive data register (dout) and raises RF. If RF is still set, the frame
// is dropped and OE is raised. FE reports a stop bit that was sampled low.
// Optional feature: define PARITY_RX_EN to add one even-parity bit between
// the data and stop bits. The result is reported on PE. Without the macro,
// PE is tied to 0.
module uart_receiver #(
    parameter int M  = 8,   // data bits per frame
    parameter int N  = 3,   // bit counter width minus 1 (must hold M)
    parameter int OS = 16   // RxC ticks per bit, power of two, >= 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         RxC,
    input  logic         RxD,
    input  logic         read,
    output logic [M-1:0] dout,
    output logic         RF,
    output logic         OE,
    output logic         FE,
    output logic         PE
);

    localparam int SW = $clog2(OS);

    // scnt values at which the line is sampled: mid start bit, and mid bit
    // once the counter has been realigned at that centre.
    localparam logic [SW-1:0] SCNT_HALF = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OS - 1);
    localparam logic [N:0]    BIT_LAST  = (N + 1)'(M - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_RX_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Synchroniser and receive FSM state.
    logic          rxd_meta_q;
    logic          rxd_s_q;
    state_t        state_q,  state_d;
    logic [SW-1:0] scnt_q,   scnt_d;
    logic [N:0]    bitcnt_q, bitcnt_d;
    logic [M-1:0]  rsdr_q,   rsdr_d;

    // Host-side receive data register and status flags.
    logic [M-1:0]  dout_q,   dout_d;
    logic          rf_q,     rf_d;
    logic          oe_q,     oe_d;
    logic          fe_q,     fe_d;

`ifdef PARITY_RX_EN
    logic          parity_q, parity_d;
    logic          pe_q,     pe_d;
`endif

    // Set by the FSM on the stop-sample tick; the frame is then offered to RDR.
    logic          xfer;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // Both flops reset to the idle-high line level, so a start bit
            // is not seen while leaving reset.
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // State register for the FSM, the shift register and the host-side flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            scnt_q   <= '0;
            bitcnt_q <= '0;
            rsdr_q   <= '0;
            dout_q   <= '0;
            rf_q     <= 1'b0;
            oe_q     <= 1'b0;
            fe_q     <= 1'b0;
`ifdef PARITY_RX_EN
            parity_q <= 1'b0;
            pe_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here let every register update
            // from the same pre-edge values, whatever the statement order.
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            bitcnt_q <= bitcnt_d;
            rsdr_q   <= rsdr_d;
            dout_q   <= dout_d;
            rf_q     <= rf_d;
            oe_q     <= oe_d;
            fe_q     <= fe_d;
`ifdef PARITY_RX_EN
            parity_q <= parity_d;
            pe_q     <= pe_d;
`endif
        end
    end

    // Next-state logic: bit framing on RxC ticks, then the RDR transfer or read clear.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statements leaves a value unassigned (no latch is inferred).
        state_d  = state_q;
        scnt_d   = scnt_q;
        bitcnt_d = bitcnt_q;
        rsdr_d   = rsdr_q;
        dout_d   = dout_q;
        rf_d     = rf_q;
        oe_d     = oe_q;
        fe_d     = fe_q;
        xfer     = 1'b0;
`ifdef PARITY_RX_EN
        parity_d = parity_q;
        pe_d     = pe_q;
`endif

        if (RxC) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = START;
                        scnt_d  = '0;
                    end
                end

                START: begin
                    if (scnt_q == SCNT_HALF) begin
                        if (!rxd_s_q) begin
                            // The start bit is still low at its centre.
                            // From here, a full bit period lands on each
                            // data bit's centre.
                            state_d  = DATA;
                            scnt_d   = '0;
                            bitcnt_d = '0;
                        end else begin
                            // The line was only a glitch. Flags stay unchanged.
                            state_d = IDLE;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end

                DATA: begin
                    if (scnt_q == SCNT_LAST) begin
                        // Shift right from the MSB, so the first bit
                        // received ends up in bit 0.
                        rsdr_d   = {rxd_s_q, rsdr_q[M-1:1]};
                        bitcnt_d = bitcnt_q + (N + 1)'(1);
                        scnt_d   = '0;
                        if (bitcnt_q == BIT_LAST) begin
`ifdef PARITY_RX_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end

`ifdef PARITY_RX_EN
                PARITY: begin
                    if (scnt_q == SCNT_LAST) begin
                        parity_d = rxd_s_q;
                        scnt_d   = '0;
                        state_d  = STOP;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
`endif

                STOP: begin
                    if (scnt_q == SCNT_LAST) begin
                        // Go straight back to IDLE. The second half of the
                        // stop bit is still high, so the next falling edge
                        // is caught on the first tick it appears.
                        xfer    = 1'b1;
                        scnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    scnt_d  = '0;
                end
            endcase
        end

        if (xfer) begin
            if (!rf_q || read) begin
                // RDR is free, or the host empties it in this same cycle.
                dout_d = rsdr_q;
                rf_d   = 1'b1;
                fe_d   = ~rxd_s_q;
                if (read) begin
                    oe_d = 1'b0;
                end
`ifdef PARITY_RX_EN
                // Even parity: data bits plus the parity bit must XOR to 0.
                // The parity bit was captured on an earlier tick.
                pe_d = ^{rsdr_q, parity_q};
`endif
            end else begin
                // RDR is still full. Keep the unread frame and drop the new one.
                oe_d = 1'b1;
            end
        end else if (read) begin
            rf_d = 1'b0;
            oe_d = 1'b0;
            fe_d = 1'b0;
`ifdef PARITY_RX_EN
            pe_d = 1'b0;
`endif
        end
    end

    assign dout = dout_q;
    assign RF   = rf_q;
    assign OE   = oe_q;
    assign FE   = fe_q;
`ifdef PARITY_RX_EN
    assign PE   = pe_q;
`else
    assign PE   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Directed testbench for uart_receiver at default parameters (M=8, OS=16).
// RxC is pulsed on every fourth clk. Frames are driven one bit per 16 ticks.
module tb_uart_receiver;

    localparam int OS = 16;
`ifdef PARITY_RX_EN
    localparam int STOP_TICK = 169;  // frame tick index of the stop sample
    localparam int LATENCY   = 168;
`else
    localparam int STOP_TICK = 153;
    localparam int LATENCY   = 152;  // OS/2 + (M+1)*OS ticks after start detect
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       RxC;
    logic       RxD;
    logic       read;
    logic [7:0] dout;
    logic       RF;
    logic       OE;
    logic       FE;
    logic       PE;

    int checks = 0;
    int passed = 0;

    uart_receiver dut (
        .clk    (clk),
        .resetn (resetn),
        .RxC    (RxC),
        .RxD    (RxD),
        .read   (read),
        .dout   (dout),
        .RF     (RF),
        .OE     (OE),
        .FE     (FE),
        .PE     (PE)
    );

    always #5 clk = ~clk;

    // One clk period: set the strobes at the falling edge.
    task automatic drive(input logic rxc, input logic rd);
        @(negedge clk);
        RxC  = rxc;
        read = rd;
    endtask

    // One RxC tick (3 quiet clks, then the tick clk). Outputs are then sampled 1ns after that edge.
    task automatic tick(input logic rd);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) tick(1'b0);
    endtask

    // Single-clk host read; outputs sampled 1ns after the edge.
    task automatic do_read();
        drive(1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Drive one frame. Frame tick 1 is the start-detect tick. The task stops
    // early after max_ticks. rf_tick returns the frame tick after which RF rose.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic rd_at_stop, input int max_ticks,
                              output int rf_tick);
        logic [10:0] bits;
        int          nbits;
        int          k;
        logic        rf_prev;
        bits    = '0;
        bits[0] = 1'b0;
        bits[8:1] = data;
`ifdef PARITY_RX_EN
        bits[9]  = ^data;
        bits[10] = stop_bit;
        nbits    = 11;
`else
        bits[9]  = stop_bit;
        nbits    = 10;
`endif
        rf_tick = -1;
        k       = 0;
        rf_prev = RF;
        for (int b = 0; b < nbits; b++) begin
            RxD = bits[b];
            for (int t = 0; t < OS; t++) begin
                k++;
                if (k > max_ticks) return;
                tick(rd_at_stop && (k == STOP_TICK));
                if (rf_tick < 0 && RF && !rf_prev) rf_tick = k;
                rf_prev = RF;
            end
        end
        RxD = 1'b1;
    endtask

`ifdef PARITY_RX_EN
    // Like send_frame, but with an explicit parity bit.
    task automatic send_parity_frame(input logic [7:0] data, input logic pbit);
        logic [10:0] bits;
        bits = {1'b1, pbit, data, 1'b0};
        for (int b = 0; b < 11; b++) begin
            RxD = bits[b];
            repeat (OS) tick(1'b0);
        end
        RxD = 1'b1;
    endtask
`endif

    task automatic test_reset();
        resetn = 1'b0;
        RxC    = 1'b0;
        RxD    = 1'b1;
        read   = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        idle(4);
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else passed++;
        checks++; if (RF !== 1'b0) $display("FAIL reset_rf: got %b expected 0", RF); else passed++;
        checks++; if (OE !== 1'b0) $display("FAIL reset_oe: got %b expected 0", OE); else passed++;
        checks++; if (FE !== 1'b0) $display("FAIL reset_fe: got %b expected 0", FE); else passed++;
        checks++; if (PE !== 1'b0) $display("FAIL reset_pe: got %b expected 0", PE); else passed++;
    endtask

    task automatic test_basic();
        int rf_tick;
        send_frame(8'hA5, 1'b1, 1'b0, 1000, rf_tick);
        checks++; if (rf_tick - 1 !== LATENCY) $display("FAIL basic_latency: got %0d ticks expected %0d", rf_tick - 1, LATENCY); else passed++;
        checks++; if (dout !== 8'hA5) $display("FAIL basic_dout: got %h expected a5", dout); else passed++;
        checks++; if (RF !== 1'b1) $display("FAIL basic_rf: got %b expected 1", RF); else passed++;
        checks++; if (FE !== 1'b0) $display("FAIL basic_fe: got %b expected 0", FE); else passed++;
        checks++; if (OE !== 1'b0) $display("FAIL basic_oe: got %b expected 0", OE); else passed++;
        checks++; if (PE !== 1'b0) $display("FAIL basic_pe: got %b expected 0", PE); else passed++;
        do_read();
        checks++; if (RF !== 1'b0) $display("FAIL basic_read_rf: got %b expected 0", RF); else passed++;
        checks++; if (dout !== 8'hA5) $display("FAIL basic_read_dout: got %h expected a5", dout); else passed++;
    endtask

    task automatic test_glitch();
        RxD = 1'b0;
        repeat (3) tick(1'b0);
        // Hold the line high for longer than a full frame. A start bit that
        // was wrongly accepted would complete here as 0xFF.
        idle(180);
        checks++; if (RF !== 1'b0) $display("FAIL glitch_rf: got %b expected 0", RF); else passed++;
        checks++; if (FE !== 1'b0) $display("FAIL glitch_fe: got %b expected 0", FE); else passed++;
        checks++; if (dout !== 8'hA5) $display("FAIL glitch_dout: got %h expected a5", dout); else passed++;
    endtask

    task automatic test_back_to_back();
        int rf_tick;
        send_frame(8'h3C, 1'b1, 1'b0, 1000, rf_tick);
        send_frame(8'h81, 1'b1, 1'b0, 1000, rf_tick);
        idle(2);
        checks++; if (dout !== 8'h3C) $display("FAIL b2b_dout: got %h expected 3c", dout); else passed++;
        checks++; if (RF !== 1'b1) $display("FAIL b2b_rf: got %b expected 1", RF); else passed++;
        checks++; if (OE !== 1'b1) $display("FAIL b2b_oe: got %b expected 1", OE); else passed++;
        checks++; if (FE !== 1'b0) $display("FAIL b2b_fe: got %b expected 0", FE); else passed++;
        do_read();
        checks++; if (RF !== 1'b0) $display("FAIL b2b_read_rf: got %b expected 0", RF); else passed++;
        checks++; if (OE !== 1'b0) $display("FAIL b2b_read_oe: got %b expected 0", OE); else passed++;
    endtask

    task automatic test_framing();
        int rf_tick;
        send_frame(8'h55, 1'b0, 1'b0, 1000, rf_tick);
        idle(20);
        checks++; if (RF !== 1'b1) $display("FAIL frame_rf: got %b expected 1", RF); else passed++;
        checks++; if (dout !== 8'h55) $display("FAIL frame_dout: got %h expected 55", dout); else passed++;
        checks++; if (FE !== 1'b1) $display("FAIL frame_fe: got %b expected 1", FE); else passed++;
        do_read();
        checks++; if (FE !== 1'b0) $display("FAIL frame_read_fe: got %b expected 0", FE); else passed++;
        checks++; if (RF !== 1'b0) $display("FAIL frame_read_rf: got %b expected 0", RF); else passed++;
    endtask

    task automatic test_read_same_cycle();
        int rf_tick;
        send_frame(8'h12, 1'b1, 1'b0, 1000, rf_tick);
        checks++; if (dout !== 8'h12) $display("FAIL same_first_dout: got %h expected 12", dout); else passed++;
        send_frame(8'h34, 1'b1, 1'b1, 1000, rf_tick);
        idle(2);
        checks++; if (dout !== 8'h34) $display("FAIL same_dout: got %h expected 34", dout); else passed++;
        checks++; if (RF !== 1'b1) $display("FAIL same_rf: got %b expected 1", RF); else passed++;
        checks++; if (OE !== 1'b0) $display("FAIL same_oe: got %b expected 0", OE); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int rf_tick;
        // RDR still holds 0x34 with RF=1. Abort a frame inside its data bits.
        send_frame(8'hFF, 1'b1, 1'b0, 60, rf_tick);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (dout !== 8'h00) $display("FAIL rstmid_dout: got %h expected 00", dout); else passed++;
        checks++; if (RF !== 1'b0) $display("FAIL rstmid_rf: got %b expected 0", RF); else passed++;
        checks++; if (OE !== 1'b0) $display("FAIL rstmid_oe: got %b expected 0", OE); else passed++;
        checks++; if (FE !== 1'b0) $display("FAIL rstmid_fe: got %b expected 0", FE); else passed++;
        checks++; if (PE !== 1'b0) $display("FAIL rstmid_pe: got %b expected 0", PE); else passed++;
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle(200);
        checks++; if (RF !== 1'b0) $display("FAIL rstmid_idle_rf: got %b expected 0", RF); else passed++;
        send_frame(8'h99, 1'b1, 1'b0, 1000, rf_tick);
        idle(2);
        checks++; if (dout !== 8'h99) $display("FAIL rstmid_next_dout: got %h expected 99", dout); else passed++;
        checks++; if (FE !== 1'b0) $display("FAIL rstmid_next_fe: got %b expected 0", FE); else passed++;
        do_read();
    endtask

`ifdef PARITY_RX_EN
    task automatic test_parity();
        send_parity_frame(8'h07, 1'b0);
        idle(2);
        checks++; if (PE !== 1'b1) $display("FAIL parity_bad_pe: got %b expected 1", PE); else passed++;
        checks++; if (dout !== 8'h07) $display("FAIL parity_bad_dout: got %h expected 07", dout); else passed++;
        do_read();
        checks++; if (PE !== 1'b0) $display("FAIL parity_read_pe: got %b expected 0", PE); else passed++;
        send_parity_frame(8'h07, 1'b1);
        idle(2);
        checks++; if (PE !== 1'b0) $display("FAIL parity_good_pe: got %b expected 0", PE); else passed++;
        checks++; if (RF !== 1'b1) $display("FAIL parity_good_rf: got %b expected 1", RF); else passed++;
        do_read();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_back_to_back();
        test_framing();
        test_read_same_cycle();
        test_reset_mid_frame();
`ifdef PARITY_RX_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
